// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// Opcode/funct values follow the MIPS-I instruction encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND,
    ALU_OR,
    ALU_ADD,
    ALU_ADDU,
    ALU_SUBU,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam int NCLS    = 13;
  localparam int C_ADDU  = 0;
  localparam int C_SUBU  = 1;
  localparam int C_SLT   = 2;
  localparam int C_ORI   = 3;
  localparam int C_ADDI  = 4;
  localparam int C_ADDIU = 5;
  localparam int C_LUI   = 6;
  localparam int C_LW    = 7;
  localparam int C_SW    = 8;
  localparam int C_BEQ   = 9;
  localparam int C_J     = 10;
  localparam int C_JAL   = 11;
  localparam int C_JR    = 12;

  typedef logic [NCLS-1:0] ins_cls_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_LUI  = 2'd1;
  localparam logic [1:0] EXT_SIGN = 2'd2;

  function automatic logic is_jump(ins_cls_t c);
    return c[C_J] | c[C_JAL] | c[C_JR];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: one-hot instruction class
// plus an illegal flag when nothing matches.
module mc_decode
  import mips_pkg::*;
#(
  parameter bit HAS_JR = 1'b1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ins_cls_t   cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o[C_ADDU] = 1'b1;
          FN_SUBU: cls_o[C_SUBU] = 1'b1;
          FN_SLT:  cls_o[C_SLT]  = 1'b1;
          FN_JR:   cls_o[C_JR]   = HAS_JR;
          default: ;
        endcase
      end
      OP_ORI:   cls_o[C_ORI]   = 1'b1;
      OP_ADDI:  cls_o[C_ADDI]  = 1'b1;
      OP_ADDIU: cls_o[C_ADDIU] = 1'b1;
      OP_LUI:   cls_o[C_LUI]   = 1'b1;
      OP_LW:    cls_o[C_LW]    = 1'b1;
      OP_SW:    cls_o[C_SW]    = 1'b1;
      OP_BEQ:   cls_o[C_BEQ]   = 1'b1;
      OP_J:     cls_o[C_J]     = 1'b1;
      OP_JAL:   cls_o[C_JAL]   = 1'b1;
      default: ;
    endcase
    illegal_o = ~|cls_o;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory timeout, sticky error
// state and a retired-instruction counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter bit HAS_JR      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             ir_valid,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       memto_reg,
  output logic             alu_src,
  output alu_op_t          alu_ctr,
  output logic [1:0]       ext_op,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  ctrl_state_t      state_q, state_d;
  ins_cls_t         cls;
  logic             illegal;
  logic             go_q;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             retire, tmo;

  // IR is only rewritten in FETCH, so op/funct stay stable per instruction
  mc_decode #(.HAS_JR(HAS_JR)) u_dec (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  assign retired = ret_q;
  assign tmo = mem_req & ~mem_ready
             & (wait_q == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      go_q    <= 1'b0;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= 1'b1;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (go_q && mem_ready) state_d = S_DECODE;
        else if (tmo)          state_d = S_ERR;
      end
      S_DECODE: begin
        if (ir_valid) begin
          if (illegal)           state_d = S_ERR;
          else if (is_jump(cls)) state_d = S_FETCH;
          else                   state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls[C_BEQ])                state_d = S_FETCH;
        else if (cls[C_LW] | cls[C_SW]) state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = cls[C_SW] ? S_FETCH : S_WB;
        else if (tmo)  state_d = S_ERR;
      end
      S_WB:    state_d = S_FETCH;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)      wait_d = '0;
    else if (mem_req && !mem_ready) wait_d = wait_q + 8'd1;
    retire = (state_q == S_WB)
           | (state_q == S_MEM && cls[C_SW] && mem_ready)
           | (state_q == S_EXEC && cls[C_BEQ])
           | (state_q == S_DECODE && ir_valid && is_jump(cls));
    ret_d = ret_q + CNT_W'(retire);
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    reg_write = 1'b0;
    memto_reg = WB_ALU;
    alu_src   = 1'b0;
    alu_ctr   = ALU_AND;
    ext_op    = EXT_SIGN;
    busy      = 1'b1;
    err       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = go_q;
        busy     = go_q;
        ir_write = go_q & mem_ready;
        pc_write = go_q & mem_ready;
      end
      S_DECODE: begin
        if (ir_valid) begin
          pc_write  = is_jump(cls);
          pc_src    = cls[C_JR] ? PC_JR
                    : (is_jump(cls) ? PC_JMP : PC_SEQ);
          reg_write = cls[C_JAL];
          memto_reg = cls[C_JAL] ? WB_LINK : WB_ALU;
        end
      end
      S_EXEC: begin
        alu_src = cls[C_ORI] | cls[C_ADDI] | cls[C_ADDIU]
                | cls[C_LUI] | cls[C_LW] | cls[C_SW];
        unique case (1'b1)
          cls[C_ORI]:                          alu_ctr = ALU_OR;
          cls[C_LW], cls[C_SW], cls[C_ADDI]:   alu_ctr = ALU_ADD;
          cls[C_SLT]:                          alu_ctr = ALU_SLT;
          cls[C_ADDU], cls[C_ADDIU]:           alu_ctr = ALU_ADDU;
          cls[C_SUBU], cls[C_BEQ]:             alu_ctr = ALU_SUBU;
          default:                             alu_ctr = ALU_AND;
        endcase
        ext_op   = cls[C_ORI] ? EXT_ZERO
                 : (cls[C_LUI] ? EXT_LUI : EXT_SIGN);
        pc_write = cls[C_BEQ] & zero;
        pc_src   = cls[C_BEQ] ? PC_BR : PC_SEQ;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = cls[C_SW];
      end
      S_WB: begin
        reg_write = 1'b1;
        memto_reg = cls[C_LW] ? WB_MEM
                  : (cls[C_LUI] ? WB_IMM : WB_ALU);
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: instruction-level schedule model drives
// randomized timing and checks every cycle of two DUT variants.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  typedef enum int {
    K_ADDU, K_SUBU, K_SLT, K_ORI, K_ADDI, K_ADDIU, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_ILL
  } kind_e;

  typedef enum int {P_IDLE, P_F, P_D, P_E, P_M, P_W, P_X} ph_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       ir_valid = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_req, a_we, a_iord, a_irw, a_pcw, a_rw, a_asrc, a_busy, a_err;
  logic [1:0] a_pcs, a_mtr, a_ext;
  alu_op_t    a_alu;
  logic [31:0] a_ret;

  logic b_req, b_we, b_iord, b_irw, b_pcw, b_rw, b_asrc, b_busy, b_err;
  logic [1:0] b_pcs, b_mtr, b_ext;
  alu_op_t    b_alu;
  logic [2:0] b_ret;

  logic [17:0] va, vb;
  assign va = {a_req, a_we, a_iord, a_irw, a_pcw, a_pcs, a_rw,
               a_mtr, a_asrc, a_alu, a_ext, a_busy, a_err};
  assign vb = {b_req, b_we, b_iord, b_irw, b_pcw, b_pcs, b_rw,
               b_mtr, b_asrc, b_alu, b_ext, b_busy, b_err};

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32), .HAS_JR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .ir_valid(ir_valid), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_req), .mem_we(a_we), .iord(a_iord),
    .ir_write(a_irw), .pc_write(a_pcw), .pc_src(a_pcs),
    .reg_write(a_rw), .memto_reg(a_mtr), .alu_src(a_asrc),
    .alu_ctr(a_alu), .ext_op(a_ext), .busy(a_busy),
    .err(a_err), .retired(a_ret)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3), .HAS_JR(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .ir_valid(ir_valid), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_req), .mem_we(b_we), .iord(b_iord),
    .ir_write(b_irw), .pc_write(b_pcw), .pc_src(b_pcs),
    .reg_write(b_rw), .memto_reg(b_mtr), .alu_src(b_asrc),
    .alu_ctr(b_alu), .ext_op(b_ext), .busy(b_busy),
    .err(b_err), .retired(b_ret)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned ret_exp = 0;
  kind_e       cur_k = K_ADDU;
  logic [5:0]  cur_op = '0;
  logic [5:0]  cur_fn = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [5:0] op_of(kind_e k);
    case (k)
      K_ORI:   return 6'h0D;
      K_ADDI:  return 6'h08;
      K_ADDIU: return 6'h09;
      K_LUI:   return 6'h0F;
      K_LW:    return 6'h23;
      K_SW:    return 6'h2B;
      K_BEQ:   return 6'h04;
      K_J:     return 6'h02;
      K_JAL:   return 6'h03;
      K_ILL:   return 6'h3F;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] fn_of(kind_e k);
    case (k)
      K_ADDU:  return 6'h21;
      K_SUBU:  return 6'h23;
      K_SLT:   return 6'h2A;
      K_JR:    return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  // expected control word for one cycle of a given instruction phase
  function automatic logic [17:0] expv(ph_e ph, kind_e k,
                                       logic rdy, logic z);
    logic mr, mw, io, irw, pw, rw, asrc, bz, er, jmp;
    logic [1:0] ps, mt, eo;
    alu_op_t ac;
    mr = 0; mw = 0; io = 0; irw = 0; pw = 0; rw = 0; asrc = 0;
    bz = 1; er = 0; ps = 0; mt = 0; eo = 2'd2; ac = ALU_AND;
    jmp = k inside {K_J, K_JAL, K_JR};
    case (ph)
      P_IDLE: bz = 0;
      P_F: begin mr = 1; irw = rdy; pw = rdy; end
      P_D: begin
        pw = jmp;
        ps = (k == K_JR) ? 2'd3 : (jmp ? 2'd2 : 2'd0);
        rw = (k == K_JAL);
        mt = (k == K_JAL) ? 2'd2 : 2'd0;
      end
      P_E: begin
        asrc = k inside {K_ORI, K_ADDI, K_ADDIU, K_LUI, K_LW, K_SW};
        case (k)
          K_ORI:              ac = ALU_OR;
          K_LW, K_SW, K_ADDI: ac = ALU_ADD;
          K_SLT:              ac = ALU_SLT;
          K_ADDU, K_ADDIU:    ac = ALU_ADDU;
          K_SUBU, K_BEQ:      ac = ALU_SUBU;
          default:            ac = ALU_AND;
        endcase
        eo = (k == K_ORI) ? 2'd0 : ((k == K_LUI) ? 2'd1 : 2'd2);
        if (k == K_BEQ) begin pw = z; ps = 2'd1; end
      end
      P_M: begin mr = 1; io = 1; mw = (k == K_SW); end
      P_W: begin
        rw = 1;
        mt = (k == K_LW) ? 2'd1 : ((k == K_LUI) ? 2'd3 : 2'd0);
      end
      P_X: begin bz = 0; er = 1; end
      default: ;
    endcase
    return {mr, mw, io, irw, pw, ps, rw, mt, asrc, ac, eo, bz, er};
  endfunction

  task automatic set_ins(input kind_e k);
    cur_k  = k;
    cur_op = op_of(k);
    cur_fn = fn_of(k);
  endtask

  task automatic step(input ph_e ph, input logic rdy,
                      input logic z, input bit chk2);
    logic [17:0] e;
    @(negedge clk);
    rst_n    = 1'b1;
    ir_valid = 1'b1;
    op       = cur_op;
    funct    = cur_fn;
    mem_ready = (ph == P_F || ph == P_M) ? rdy : 1'($urandom);
    zero      = (ph == P_E) ? z : 1'($urandom);
    #2;
    e = expv(ph, cur_k, rdy, z);
    chk($sformatf("ctl ph%0d k%0d", ph, cur_k), va, e);
    chk("retired", a_ret, ret_exp);
    if (chk2) begin
      chk($sformatf("ctl2 ph%0d k%0d", ph, cur_k), vb, e);
      chk("retired2", b_ret, ret_exp % 8);
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = rdy;
    zero      = 1'($urandom);
    ret_exp   = 0;
    step(P_IDLE, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_instr(input kind_e k, input int fd, input int md,
                           input logic z, input bit chk2);
    set_ins(k);
    for (int i = 0; i <= fd; i++) step(P_F, i == fd, z, chk2);
    step(P_D, 1'b0, z, chk2);
    if (k == K_ILL) begin
      step(P_X, 1'b0, z, chk2);
    end else begin
      if (!(k inside {K_J, K_JAL, K_JR})) step(P_E, 1'b0, z, chk2);
      if (k inside {K_LW, K_SW})
        for (int i = 0; i <= md; i++) step(P_M, i == md, z, chk2);
      if (!(k inside {K_J, K_JAL, K_JR, K_BEQ, K_SW}))
        step(P_W, 1'b0, z, chk2);
      ret_exp++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset(1'b1);
    run_instr(K_ADDU, 0, 0, 1'b0, 1'b1);
    run_instr(K_LW, 3, 3, 1'b0, 1'b1);
    run_instr(K_BEQ, 0, 0, 1'b1, 1'b1);
    run_instr(K_BEQ, 0, 0, 1'b0, 1'b1);
    run_instr(K_JAL, 1, 0, 1'b0, 1'b1);
    run_instr(K_SW, 1, 2, 1'b0, 1'b1);
    run_instr(K_LUI, 0, 0, 1'b0, 1'b1);
    run_instr(K_ORI, 2, 0, 1'b0, 1'b1);
    run_instr(K_J, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 60; n++)
      run_instr(kind_e'($urandom_range(0, 11)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom), 1'b1);

    do_reset(1'b0);
    run_instr(K_ADDU, 0, 0, 1'b0, 1'b1);
    run_instr(K_ILL, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(P_X, 1'b0, 1'b0, 1'b1);

    do_reset(1'b0);
    run_instr(K_JR, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("nojr_err", b_err, 1);
    chk("nojr_ret", b_ret, 0);

    do_reset(1'b0);
    set_ins(K_ADDU);
    for (int i = 0; i < 4; i++) step(P_F, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 22; i++) step(P_X, 1'b0, 1'b0, 1'b1);

    do_reset(1'b0);
    set_ins(K_LW);
    step(P_F, 1'b1, 1'b0, 1'b1);
    step(P_D, 1'b0, 1'b0, 1'b1);
    step(P_E, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(P_M, 1'b0, 1'b0, 1'b1);
    step(P_X, 1'b0, 1'b0, 1'b1);
    step(P_X, 1'b0, 1'b0, 1'b1);

    do_reset(1'b0);
    set_ins(K_LW);
    step(P_F, 1'b1, 1'b0, 1'b1);
    step(P_D, 1'b0, 1'b0, 1'b1);
    step(P_E, 1'b0, 1'b0, 1'b1);
    step(P_M, 1'b0, 1'b0, 1'b1);
    do_reset(1'b1);
    run_instr(K_SUBU, 0, 0, 1'b0, 1'b1);
    run_instr(K_SLT, 1, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
